// File: rtl/beat_timing_pkg.sv
// Shared types and default sizing for the beat (W-phase) timing generator.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package beat_timing_pkg;

    // Beat state. IDLE is the all-zero code, so a cleared register is a halted machine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        W3   = 2'd3
    } beat_state_t;

    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/beat_timing_gen_qd_sync.sv
// Start-button synchroniser plus rising-edge detect; one t3-wide pulse per press.
// Latency: qd_rise is high SYNC_STAGES posedges after qd rises; a held button gives one pulse.
// Backpressure: none; the pulse is lost if the consumer is not in a state to take it.
// Ports: t3 clock, clr async active-low reset, qd raw button, qd_rise one-cycle pulse.
module qd_sync
    import beat_timing_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF   // must be >= 2
) (
    input  logic t3,
    input  logic clr,
    input  logic qd,
    output logic qd_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge t3 or negedge clr) begin
        if (!clr) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], qd};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Combinational edge from the last synchroniser stage so that the FSM
    // acts on the very next posedge (press-to-W1 = SYNC_STAGES+1 edges).
    assign qd_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/beat_timing_gen.sv
// Beat generator feeding the hardwired controller: one-hot w1/w2/w3, run/halt, cycle counter.
// Latency: qd press to w1 = SYNC_STAGES+1 posedges; stop at edge k clears all beats after edge k.
// Backpressure: none; controller feedback (short/long/stop) is acted on at the same edge it is sampled.
// Ports: t3 beat clock, clr async active-low reset, qd start button, step single-step mode,
//        short/long/stop controller feedback, w1/w2/w3 beats, running flag, cyc_cnt completed cycles.
module beat_timing_gen
    import beat_timing_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             step,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CNT_W-1:0] cyc_cnt
);

    beat_state_t state_q, state_nx;
    logic        run_nx;
    logic        cyc_end;
    logic        qd_rise;

    qd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_qd_sync (
        .t3      (t3),
        .clr     (clr),
        .qd      (qd),
        .qd_rise (qd_rise)
    );

    always_ff @(posedge t3 or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            running <= 1'b0;
            cyc_cnt <= '0;
        end else begin
            state_q <= state_nx;
            running <= run_nx;
            if (cyc_end) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        run_nx   = running;
        cyc_end  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Start is only honoured from a halted machine.
                if (qd_rise) begin
                    state_nx = W1;
                    run_nx   = 1'b1;
                end
            end
            W1: begin
                cyc_end  = short;
                state_nx = short ? W1 : W2;
            end
            W2: begin
                cyc_end  = ~long;
                state_nx = long ? W3 : W1;
            end
            W3: begin
                cyc_end  = 1'b1;
                state_nx = W1;
            end
            default: ;
        endcase

        // Halt overrides the beat sequencing above but not the cycle-end
        // decision, so a cycle that finishes on the halting beat is still counted.
        if (state_q != IDLE && (stop || (cyc_end && step))) begin
            state_nx = IDLE;
            run_nx   = 1'b0;
        end
    end

    assign w1 = (state_q == W1);
    assign w2 = (state_q == W2);
    assign w3 = (state_q == W3);

endmodule

// File: tb/tb_beat_timing_gen.sv
module tb_beat_timing_gen;

    localparam int CNT_W = 2;

    logic             t3;
    logic             clr;
    logic             qd;
    logic             step;
    logic             short;
    logic             long;
    logic             stop;
    logic             w1;
    logic             w2;
    logic             w3;
    logic             running;
    logic [CNT_W-1:0] cyc_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;

    beat_timing_gen #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .t3      (t3),
        .clr     (clr),
        .qd      (qd),
        .step    (step),
        .short   (short),
        .long    (long),
        .stop    (stop),
        .w1      (w1),
        .w2      (w2),
        .w3      (w3),
        .running (running),
        .cyc_cnt (cyc_cnt)
    );

    initial t3 = 1'b0;
    always #5 t3 = ~t3;

    task automatic tick();
        @(posedge t3);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // exp_w is {w1,w2,w3}
    task automatic chk_st(input string tag, input logic [2:0] exp_w, input logic exp_run);
        logic [31:0] ec;
        ec = exp_cnt;
        chk({tag, "/w"},   {5'b0, w1, w2, w3}, {5'b0, exp_w});
        chk({tag, "/run"}, {7'b0, running},    {7'b0, exp_run});
        chk({tag, "/cnt"}, {6'b0, cyc_cnt},    {6'b0, ec[1:0]});
    endtask

    // Press qd now; W1 must appear on the third posedge. qd is left high.
    task automatic press(input string tag);
        qd = 1'b1;
        tick();
        tick();
        chk({tag, "/lat2"}, {5'b0, w1, w2, w3}, 8'h00);
        tick();
        chk_st({tag, "/w1"}, 3'b100, 1'b1);
    endtask

    // One plain W2 -> W1 cycle starting from W1.
    task automatic plain_cycle(input string tag);
        tick();
        chk_st({tag, "/w2"}, 3'b010, 1'b1);
        tick();
        exp_cnt++;
        chk_st({tag, "/w1"}, 3'b100, 1'b1);
    endtask

    initial begin
        clr   = 1'b0;
        qd    = 1'b0;
        step  = 1'b0;
        short = 1'b0;
        long  = 1'b0;
        stop  = 1'b0;
        #3;
        chk_st("reset", 3'b000, 1'b0);
        @(negedge t3);
        clr = 1'b1;
        tick();
        chk_st("idle_after_reset", 3'b000, 1'b0);

        // Plain cycles with qd held: exactly one start.
        press("start_plain");
        for (int i = 0; i < 3; i++) plain_cycle("plain");
        qd = 1'b0;

        // Asynchronous reset in the middle of W2.
        tick();
        chk_st("pre_reset_w2", 3'b010, 1'b1);
        #2;
        clr = 1'b0;
        #1;
        exp_cnt = 0;
        chk_st("reset_mid", 3'b000, 1'b0);
        @(negedge t3);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_st("post_reset_idle", 3'b000, 1'b0);
        end

        // short in W1, long in W2, long/short ignored in W3, long ignored in W1.
        press("start_sl");
        qd    = 1'b0;
        short = 1'b1;
        tick();
        exp_cnt++;
        chk_st("short_w1", 3'b100, 1'b1);
        short = 1'b0;
        tick();
        chk_st("short_then_w2", 3'b010, 1'b1);
        long = 1'b1;
        tick();
        chk_st("long_w3", 3'b001, 1'b1);
        short = 1'b1;
        tick();
        exp_cnt++;
        chk_st("w3_end", 3'b100, 1'b1);
        short = 1'b0;
        tick();
        chk_st("long_ign_w1", 3'b010, 1'b1);
        long = 1'b0;
        tick();
        exp_cnt++;
        chk_st("w2_end", 3'b100, 1'b1);

        // stop beats short, and the cycle is still counted (wraps 3 -> 0).
        stop  = 1'b1;
        short = 1'b1;
        tick();
        exp_cnt++;
        chk_st("stop_short", 3'b000, 1'b0);
        stop  = 1'b0;
        short = 1'b0;
        tick();
        chk_st("stop_hold", 3'b000, 1'b0);

        // stop in W2 with long=1: not a cycle end, no count.
        press("restart1");
        qd = 1'b0;
        tick();
        chk_st("w2_again", 3'b010, 1'b1);
        stop = 1'b1;
        long = 1'b1;
        tick();
        chk_st("stop_long_w2", 3'b000, 1'b0);
        stop = 1'b0;
        long = 1'b0;
        tick();

        // Counter wrap: 5 cycles -> 1,2,3,0,1.
        press("restart2");
        qd = 1'b0;
        for (int i = 0; i < 5; i++) plain_cycle("wrap");

        // qd_rise coinciding with a halt edge is ignored.
        qd = 1'b1;
        tick();
        chk_st("sim_w2", 3'b010, 1'b1);
        tick();
        exp_cnt++;
        chk_st("sim_w1", 3'b100, 1'b1);
        stop = 1'b1;
        tick();
        chk_st("sim_halt", 3'b000, 1'b0);
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_st("sim_stay_idle", 3'b000, 1'b0);
        end
        qd = 1'b0;
        tick();
        tick();
        tick();

        // Single-step: each press gives one W1,W2 cycle then IDLE.
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            press("step_start");
            if (i != 0) qd = 1'b0;
            tick();
            chk_st("step_w2", 3'b010, 1'b1);
            tick();
            exp_cnt++;
            chk_st("step_end", 3'b000, 1'b0);
            if (i == 0) begin
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk_st("step_held_idle", 3'b000, 1'b0);
                end
                qd = 1'b0;
            end
            tick();
            tick();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
